// File: rtl/pattern_sequencer.sv
// Step sequencer driving one tone-generator voice from a small writable pattern memory.
// Optional `define PATTERN_SEQ_GATE_GAP_EN inserts a one-tick gate-low GAP between steps.
module pattern_sequencer #(
    parameter int FREQ_BITS = 16,
    parameter int ADDR_BITS = 4,
    parameter int DUR_BITS  = 8,
    parameter int DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [FREQ_BITS-1:0] wr_freq,
    input  logic [3:0]           wr_wave,
    input  logic [DUR_BITS-1:0]  wr_dur,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [ADDR_BITS-1:0] last_step,
    input  logic [DIV_BITS-1:0]  tick_div,
    output logic [FREQ_BITS-1:0] tone_freq,
    output logic                 en_noise,
    output logic                 en_pulse,
    output logic                 en_triangle,
    output logic                 en_saw,
    output logic                 gate,
    output logic [ADDR_BITS-1:0] step_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int DEPTH = 1 << ADDR_BITS;

`ifdef PATTERN_SEQ_GATE_GAP_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2,
                              S_GAP = 3'd3, S_DONE = 3'd4} state_t;
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2,
                              S_DONE = 3'd4} state_t;
`endif

    state_t r_state, w_next;

    logic [FREQ_BITS-1:0] r_mem_freq [DEPTH];
    logic [3:0]           r_mem_wave [DEPTH];
    logic [DUR_BITS-1:0]  r_mem_dur  [DEPTH];

    logic [ADDR_BITS-1:0] r_step, r_last;
    logic [DIV_BITS-1:0]  r_presc;
    logic [DUR_BITS-1:0]  r_remain;
    logic [FREQ_BITS-1:0] r_freq;
    logic [3:0]           r_wave;
    logic                 r_gate;

    logic                 w_tick, w_step_end, w_at_last, w_rest;
    logic [DUR_BITS-1:0]  w_cur_dur;

    assign w_cur_dur  = r_mem_dur[r_step];
    assign w_rest     = (w_cur_dur == '0);
    assign w_tick     = (r_presc == tick_div);
    assign w_step_end = (r_state == S_PLAY) && w_tick && (r_remain == DUR_BITS'(1));
    assign w_at_last  = (r_step == r_last);

    // Pattern memory has no reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_freq[wr_addr] <= wr_freq;
            r_mem_wave[wr_addr] <= wr_wave;
            r_mem_dur[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = S_PLAY;
            S_PLAY: begin
                if (w_step_end) begin
                    if (!w_at_last || loop_en) begin
`ifdef PATTERN_SEQ_GATE_GAP_EN
                        w_next = S_GAP;
`else
                        w_next = S_LOAD;
`endif
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
`ifdef PATTERN_SEQ_GATE_GAP_EN
            S_GAP:  if (w_tick) w_next = S_LOAD;
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // stop overrides everything, including a simultaneous start in IDLE
        if (stop) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step   <= '0;
            r_last   <= '0;
            r_presc  <= '0;
            r_remain <= '0;
            r_freq   <= '0;
            r_wave   <= '0;
            r_gate   <= 1'b0;
        end else if (stop && r_state != S_IDLE) begin
            r_step <= '0;
            r_freq <= '0;
            r_wave <= '0;
            r_gate <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_step <= '0;
                        r_last <= last_step;
                    end
                end
                S_LOAD: begin
                    r_freq   <= w_rest ? '0 : r_mem_freq[r_step];
                    r_wave   <= w_rest ? '0 : r_mem_wave[r_step];
                    r_gate   <= !w_rest;
                    r_remain <= w_rest ? DUR_BITS'(1) : w_cur_dur;
                    r_presc  <= '0;
                end
                S_PLAY: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) r_remain <= r_remain - 1'b1;
                    if (w_step_end) begin
                        if (!w_at_last) begin
                            r_step <= r_step + 1'b1;
                        end else if (loop_en) begin
                            r_step <= '0;
                        end else begin
                            r_step <= '0;
                            r_freq <= '0;
                            r_wave <= '0;
                            r_gate <= 1'b0;
                        end
                    end
                end
`ifdef PATTERN_SEQ_GATE_GAP_EN
                S_GAP: r_presc <= w_tick ? '0 : r_presc + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign tone_freq   = r_freq;
    assign en_noise    = r_wave[3];
    assign en_pulse    = r_wave[2];
    assign en_triangle = r_wave[1];
    assign en_saw      = r_wave[0];
    assign step_idx    = r_step;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
`ifdef PATTERN_SEQ_GATE_GAP_EN
    // Only the gate drops in GAP; the held step values stay on the other outputs.
    assign gate        = r_gate && (r_state != S_GAP);
`else
    assign gate        = r_gate;
`endif

endmodule
